// File: rtl/mt8816_shadow_if.sv
// mt8816_shadow_if
//   Groups the snooped MT8816 control bus, the readback port and the
//   status outputs of mt8816_shadow. Signal names carry the direction as
//   seen from the shadow block: i_* are driven into it and o_* come out.
//
//   Snooped bus : i_sw_reset, i_sw_cs, i_sw_strobe, i_sw_ax[3:0] (physical),
//                 i_sw_ay[2:0], i_sw_data
//   Readback    : i_rd_en, i_rd_ax[3:0] (logical), i_rd_ay[2:0] ->
//                 o_rd_valid, o_rd_data (1 clk later)
//   Status      : o_state[127:0], o_write_cnt[15:0], i_err_clr, o_err,
//                 o_err_code[2:0]
//
//   master : the side that drives the snooped bus and readback requests
//   slave  : the shadow block itself
interface mt8816_shadow_if;
  logic         i_sw_reset;
  logic         i_sw_cs;
  logic         i_sw_strobe;
  logic [3:0]   i_sw_ax;
  logic [2:0]   i_sw_ay;
  logic         i_sw_data;
  logic         i_rd_en;
  logic [3:0]   i_rd_ax;
  logic [2:0]   i_rd_ay;
  logic         i_err_clr;
  logic         o_rd_valid;
  logic         o_rd_data;
  logic [127:0] o_state;
  logic [15:0]  o_write_cnt;
  logic         o_err;
  logic [2:0]   o_err_code;

  modport master (
    output i_sw_reset, i_sw_cs, i_sw_strobe, i_sw_ax, i_sw_ay, i_sw_data,
    output i_rd_en, i_rd_ax, i_rd_ay, i_err_clr,
    input  o_rd_valid, o_rd_data, o_state, o_write_cnt, o_err, o_err_code
  );

  modport slave (
    input  i_sw_reset, i_sw_cs, i_sw_strobe, i_sw_ax, i_sw_ay, i_sw_data,
    input  i_rd_en, i_rd_ax, i_rd_ay, i_err_clr,
    output o_rd_valid, o_rd_data, o_state, o_write_cnt, o_err, o_err_code
  );
endinterface

// File: rtl/mt8816_shadow.sv
// mt8816_shadow
//   Passive receiver for the MT8816 crosspoint control bus. It snoops the
//   RESET/CS/STROBE/AX/AY/DATA lines driven to the switch chip, keeps a
//   16x8 shadow of the crosspoint array indexed by logical AX, offers a
//   1-clk readback port and flags protocol violations.
//
//   Ports
//     i_fpga_clk : 100 MHz clock
//     i_reset_n  : asynchronous active-low reset
//     bus        : mt8816_shadow_if.slave (snooped bus, readback, status)
//
//   Error code bits (sticky until i_err_clr, a new error in the same cycle
//   wins over the clear):
//     [0] STROBE seen while CS low
//     [1] AX/AY/DATA changed while STROBE high
//     [2] STROBE shorter than MIN_STROBE_CYC (write dropped)
module mt8816_shadow #(
  parameter int MIN_STROBE_CYC = 2,
  parameter bit REMAP_EN       = 1'b1
) (
  input logic            i_fpga_clk,
  input logic            i_reset_n,
  mt8816_shadow_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_STROBE = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  // Board wiring swaps the physical AX lines; convert back to logical AX.
  function automatic logic [3:0] f_remap(input logic [3:0] phys);
    logic [3:0] logical;
    logical = phys;
    if (REMAP_EN) begin
      if (phys >= 4'h8 && phys <= 4'hD) logical = phys - 4'd2;
      else if (phys == 4'h6)            logical = 4'hC;
      else if (phys == 4'h7)            logical = 4'hD;
    end
    return logical;
  endfunction

  // Registered copy of the snooped bus; the FSM works only on these.
  logic         r_sw_reset;
  logic         r_sw_cs;
  logic         r_sw_strobe;
  logic [3:0]   r_sw_ax;
  logic [2:0]   r_sw_ay;
  logic         r_sw_data;

  state_t       r_state;
  state_t       w_state_next;

  logic [3:0]   r_lat_ax;
  logic [2:0]   r_lat_ay;
  logic         r_lat_data;
  logic [7:0]   r_width;

  logic [127:0] r_shadow;
  logic [15:0]  r_write_cnt;
  logic [2:0]   r_err_code;
  logic         r_err;
  logic         r_rd_valid;
  logic         r_rd_data;

  logic         w_sample;
  logic         w_leave;
  logic         w_commit;
  logic         w_short;
  logic         w_glitch;
  logic         w_nocs;
  logic [6:0]   w_commit_idx;
  logic [2:0]   w_err_code_next;

  always_ff @(posedge i_fpga_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sw_reset  <= 1'b0;
      r_sw_cs     <= 1'b0;
      r_sw_strobe <= 1'b0;
      r_sw_ax     <= 4'd0;
      r_sw_ay     <= 3'd0;
      r_sw_data   <= 1'b0;
    end else begin
      r_sw_reset  <= bus.i_sw_reset;
      r_sw_cs     <= bus.i_sw_cs;
      r_sw_strobe <= bus.i_sw_strobe;
      r_sw_ax     <= bus.i_sw_ax;
      r_sw_ay     <= bus.i_sw_ay;
      r_sw_data   <= bus.i_sw_data;
    end
  end

  // Next-state logic; chip RESET overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    if (r_sw_reset) begin
      w_state_next = ST_CLEAR;
    end else begin
      case (r_state)
        ST_CLEAR:  w_state_next = ST_IDLE;
        ST_IDLE: begin
          if (r_sw_cs) w_state_next = r_sw_strobe ? ST_STROBE : ST_SELECT;
        end
        ST_SELECT: begin
          if (r_sw_strobe)   w_state_next = ST_STROBE;
          else if (!r_sw_cs) w_state_next = ST_IDLE;
        end
        ST_STROBE: begin
          if (!r_sw_strobe) w_state_next = r_sw_cs ? ST_SELECT : ST_IDLE;
        end
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // Every cycle with a valid strobe (entering or staying in STROBE) is a
  // sample: it latches the bus and counts toward the strobe width.
  always_comb begin
    w_sample     = (w_state_next == ST_STROBE);
    w_leave      = (r_state == ST_STROBE) &&
                   ((w_state_next == ST_IDLE) || (w_state_next == ST_SELECT));
    w_commit     = w_leave && (r_width >= 8'(MIN_STROBE_CYC));
    w_short      = w_leave && !w_commit;
    // Only compare against a previous sample, i.e. not on the entry cycle.
    w_glitch     = (r_state == ST_STROBE) && w_sample &&
                   ({r_sw_ax, r_sw_ay, r_sw_data} != {r_lat_ax, r_lat_ay, r_lat_data});
    w_nocs       = (r_state == ST_IDLE) && !r_sw_reset && !r_sw_cs && r_sw_strobe;
    w_commit_idx = {f_remap(r_lat_ax), r_lat_ay};
    w_err_code_next = (bus.i_err_clr ? 3'b000 : r_err_code) |
                      {w_short, w_glitch, w_nocs};
  end

  always_ff @(posedge i_fpga_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_lat_ax   <= 4'd0;
      r_lat_ay   <= 3'd0;
      r_lat_data <= 1'b0;
      r_width    <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (w_sample) begin
        r_lat_ax   <= r_sw_ax;
        r_lat_ay   <= r_sw_ay;
        r_lat_data <= r_sw_data;
        if (r_state != ST_STROBE)  r_width <= 8'd1;
        else if (r_width != 8'hFF) r_width <= r_width + 8'd1;
      end
    end
  end

  // Shadow array and write counter. CLEAR wipes the array but the write
  // counter keeps its history until the FPGA reset.
  always_ff @(posedge i_fpga_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shadow    <= '0;
      r_write_cnt <= 16'd0;
    end else begin
      if (r_state == ST_CLEAR) r_shadow <= '0;
      else if (w_commit)       r_shadow[w_commit_idx] <= r_lat_data;
      if (w_commit && (r_write_cnt != 16'hFFFF)) r_write_cnt <= r_write_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_fpga_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_err_code <= 3'b000;
      r_err      <= 1'b0;
    end else begin
      r_err_code <= w_err_code_next;
      r_err      <= |w_err_code_next;
    end
  end

  // Readback reads the register before any same-edge commit lands.
  always_ff @(posedge i_fpga_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 1'b0;
    end else begin
      r_rd_valid <= bus.i_rd_en;
      r_rd_data  <= bus.i_rd_en ? r_shadow[{bus.i_rd_ax, bus.i_rd_ay}] : 1'b0;
    end
  end

  assign bus.o_state     = r_shadow;
  assign bus.o_write_cnt = r_write_cnt;
  assign bus.o_err_code  = r_err_code;
  assign bus.o_err       = r_err;
  assign bus.o_rd_valid  = r_rd_valid;
  assign bus.o_rd_data   = r_rd_data;

endmodule
